ex_wb_stage: RTL

EX_WB_STAGE -- requirements
Module: ex_wb_stage

---
 rtl/ex_wb_stage.sv | 96 +++++++++
 1 files changed

// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register with commit into a 2^AW-entry register file,
// same-cycle bypass on the ID read ports and a saturating retired counter.
module ex_wb_stage #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ex_valid,
   input  logic          ex_reg_write,
   input  logic [AW-1:0] ex_rd,
   input  logic [DW-1:0] ex_result,
   input  logic          stall,
   input  logic          flush,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   output logic [DW-1:0] rs_data,
   output logic [DW-1:0] rt_data,
   output logic          reg_write_exwb,
   output logic [AW-1:0] rd_exwb,
   output logic [DW-1:0] result_exwb,
   output logic [15:0]   retired_count
);

   localparam int unsigned NREG = 1 << AW;
   localparam int unsigned CW   = 16;

   typedef struct packed {
      logic          valid;
      logic          reg_write;
      logic [AW-1:0] rd;
      logic [DW-1:0] result;
   } exwb_t;

   exwb_t         pipe_q;
   logic [DW-1:0] rf_q [NREG];
   logic [CW-1:0] cnt_q;

   logic commit_c;
   logic wr_en_c;

   // Commit depends only on stall; flush only kills the incoming instruction.
   assign commit_c = pipe_q.valid & ~stall;
   assign wr_en_c  = commit_c & pipe_q.reg_write;

   // Pipeline register: flush beats stall beats load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_q <= '0;
      end else if (flush) begin
         pipe_q.valid     <= 1'b0;
         pipe_q.reg_write <= 1'b0;
      end else if (!stall) begin
         pipe_q.valid     <= ex_valid;
         pipe_q.reg_write <= ex_reg_write;
         pipe_q.rd        <= ex_rd;
         pipe_q.result    <= ex_result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREG); i++) begin
            rf_q[i] <= '0;
         end
      end else if (wr_en_c) begin
         rf_q[pipe_q.rd] <= pipe_q.result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (commit_c && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   // Read ports see the value being written this cycle.
   always_comb begin
      rs_data = rf_q[rs_addr];
      rt_data = rf_q[rt_addr];
      if (wr_en_c && (rs_addr == pipe_q.rd)) begin
         rs_data = pipe_q.result;
      end
      if (wr_en_c && (rt_addr == pipe_q.rd)) begin
         rt_data = pipe_q.result;
      end
   end

   assign reg_write_exwb = pipe_q.valid & pipe_q.reg_write;
   assign rd_exwb        = pipe_q.rd;
   assign result_exwb    = pipe_q.result;
   assign retired_count  = cnt_q;

endmodule
